// File: rtl/read_cycle.sv
// read_cycle: bus-master FSM for one RTC read transaction on the multiplexed
// AD/CS/RD/WR interface. Address phase strobed with WR, bus turnaround,
// read strobe with data capture, then recovery.
// Optional build macro: READ_ABORT_EN adds abort/aborted ports.
module read_cycle #(
  parameter int unsigned T_ACC = 4,
  parameter int unsigned T_ADT = 2,
  parameter int unsigned T_W   = 3,
  parameter int unsigned T_RD  = 4,
  parameter int unsigned CW    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   addr,
  input  logic [7:0]   data_in,
`ifdef READ_ABORT_EN
  input  logic         abort,
  output logic         aborted,
`endif
  output logic [7:0]   bus_out,
  output logic         bus_oe,
  output logic [7:0]   data_out,
  output logic         AD,
  output logic         CS,
  output logic         RD,
  output logic         WR,
  output logic         ad_mux,
  output logic         busy,
  output logic         read_end,
  output logic [2:0]   state
);

  localparam int unsigned DW = 8;

  // Effective phase lengths: zero is treated as one cycle.
  localparam int unsigned E_ACC = (T_ACC == 0) ? 1 : T_ACC;
  localparam int unsigned E_ADT = (T_ADT == 0) ? 1 : T_ADT;
  localparam int unsigned E_W   = (T_W   == 0) ? 1 : T_W;
  localparam int unsigned E_RD  = (T_RD  == 0) ? 1 : T_RD;

  localparam logic [CW-1:0] L_ACC = CW'(E_ACC - 1);
  localparam logic [CW-1:0] L_ADT = CW'(E_ADT - 1);
  localparam logic [CW-1:0] L_W   = CW'(E_W - 1);
  localparam logic [CW-1:0] L_RD  = CW'(E_RD - 1);

  typedef enum logic [2:0] {
    R0 = 3'd0,
    R1 = 3'd1,
    R2 = 3'd2,
    R3 = 3'd3,
    R4 = 3'd4,
    R5 = 3'd5,
    R6 = 3'd6,
    R7 = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt;
  logic            w_timer_end;
  logic            w_ld_addr;
  logic            w_cap;
  logic [DW-1:0]   r_addr_q;
  logic [DW-1:0]   r_data_out;
  logic [6:0]      w_ctl;
  logic [6:0]      r_ctl;
  logic            r_busy;

`ifdef READ_ABORT_EN
  logic            r_abrt;
  logic            w_abrt_set;
  logic            r_aborted;
`endif

  // Strobe decode per state: {AD, CS, RD, WR, ad_mux, bus_oe, read_end}.
  function automatic logic [6:0] decode(input state_t s);
    logic [6:0] v;
    v = 7'b1111000;
    unique case (s)
      R0: v = 7'b1111000;
      R1: v = 7'b0111010;
      R2: v = 7'b0010010;
      R3: v = 7'b0111010;
      R4: v = 7'b1111100;
      R5: v = 7'b1001100;
      R6: v = 7'b1111100;
      R7: v = 7'b1111101;
    endcase
    return v;
  endfunction

  assign w_timer_end = (r_cnt == '0);

  // Next-state, phase timer reload and capture/latch enables.
  always_comb begin
    w_next    = r_state;
    w_cnt     = w_timer_end ? '0 : (r_cnt - CW'(1));
    w_ld_addr = 1'b0;
    w_cap     = 1'b0;
`ifdef READ_ABORT_EN
    w_abrt_set = 1'b0;
`endif
    unique case (r_state)
      R0: begin
        if (start) begin
          w_next    = R1;
          w_ld_addr = 1'b1;
        end
      end
      R1: begin
        w_next = R2;
        w_cnt  = L_ACC;
      end
      R2: begin
        if (w_timer_end) begin
          w_next = R3;
          w_cnt  = L_ADT;
        end
      end
      R3: begin
        if (w_timer_end) begin
          w_next = R4;
          w_cnt  = L_W;
        end
      end
      R4: begin
        if (w_timer_end) begin
          w_next = R5;
          w_cnt  = L_RD;
        end
      end
      R5: begin
        if (w_timer_end) begin
          w_next = R6;
          w_cnt  = L_W;
          w_cap  = 1'b1;
        end
      end
      R6: begin
        if (w_timer_end) begin
`ifdef READ_ABORT_EN
          w_next = r_abrt ? R0 : R7;
`else
          w_next = R7;
`endif
        end
      end
      R7: begin
        w_next = R0;
      end
    endcase
`ifdef READ_ABORT_EN
    // Abort during the active phases jumps straight to recovery without capture.
    if (abort && (r_state inside {R1, R2, R3, R4, R5})) begin
      w_next     = R6;
      w_cnt      = L_W;
      w_cap      = 1'b0;
      w_abrt_set = 1'b1;
    end
`endif
    w_ctl = decode(w_next);
  end

  // State, timer, latched address, captured byte and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= R0;
      r_cnt      <= '0;
      r_addr_q   <= '0;
      r_data_out <= '0;
      r_ctl      <= decode(R0);
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_ctl   <= w_ctl;
      r_busy  <= (w_next != R0);
      if (w_ld_addr) r_addr_q <= addr;
      if (w_cap)     r_data_out <= data_in;
    end
  end

`ifdef READ_ABORT_EN
  // Abort bookkeeping: remember the abort, pulse aborted on return to idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_abrt    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= r_abrt && (r_state == R6) && (w_next == R0);
      if (w_abrt_set)         r_abrt <= 1'b1;
      else if (w_next == R0)  r_abrt <= 1'b0;
    end
  end

  assign aborted = r_aborted;
`endif

  assign {AD, CS, RD, WR, ad_mux, bus_oe, read_end} = r_ctl;
  assign bus_out  = r_addr_q;
  assign data_out = r_data_out;
  assign busy     = r_busy;
  assign state    = r_state;

endmodule

// File: tb/tb_read_cycle.sv
// tb_read_cycle: directed bench for read_cycle with a data scoreboard.
// Optional build macro: READ_ABORT_EN enables the abort scenario.
module tb_read_cycle;

  localparam int unsigned T_ACC = 4;
  localparam int unsigned T_ADT = 2;
  localparam int unsigned T_W   = 3;
  localparam int unsigned T_RD  = 4;
  localparam int unsigned LAT   = 1 + T_ACC + T_ADT + 2 * T_W + T_RD;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] data_out;
  logic       AD, CS, RD, WR, ad_mux, busy, read_end;
  logic [2:0] state;
`ifdef READ_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  read_cycle dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .addr     (addr),
    .data_in  (data_in),
`ifdef READ_ABORT_EN
    .abort    (abort),
    .aborted  (aborted),
`endif
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .data_out (data_out),
    .AD       (AD),
    .CS       (CS),
    .RD       (RD),
    .WR       (WR),
    .ad_mux   (ad_mux),
    .busy     (busy),
    .read_end (read_end),
    .state    (state)
  );

  // Expected {AD, CS, RD, WR, ad_mux, bus_oe, read_end} for each state.
  function automatic logic [6:0] exp_ctl(input int s);
    case (s)
      1, 3:    return 7'b0111010;
      2:       return 7'b0010010;
      4, 6:    return 7'b1111100;
      5:       return 7'b1001100;
      7:       return 7'b1111101;
      default: return 7'b1111000;
    endcase
  endfunction

  function automatic int dur(input int s);
    case (s)
      2:       return T_ACC;
      3:       return T_ADT;
      4, 6:    return T_W;
      5:       return T_RD;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction, starting at a negedge with the DUT in R0.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] d_early,
                         input logic [7:0] d_last, input bit mid_pulse,
                         input bit hold_next, input logic [7:0] a_next);
    int cyc;
    logic [7:0] e;
    addr  = a;
    start = 1'b1;
    exp_q.push_back(d_last);
    @(negedge clk);
    start = 1'b0;
    addr  = 8'h5C;
    cyc   = 1;
    for (int s = 1; s <= 7; s++) begin
      for (int k = 0; k < dur(s); k++) begin
        chk("state", 32'(state), 32'(s));
        chk("ctl", 32'({AD, CS, RD, WR, ad_mux, bus_oe, read_end}), 32'(exp_ctl(s)));
        chk("busy", 32'(busy), 32'd1);
        chk("rd_wr_excl", 32'(!RD && !WR), 32'd0);
        if (bus_oe) chk("bus_out", 32'(bus_out), 32'(a));
        if (mid_pulse && s == 4 && k == 1) begin
          start = 1'b1;
          addr  = 8'h22;
        end else if (mid_pulse && s == 4 && k == 2) begin
          start = 1'b0;
          addr  = 8'h5C;
        end
        if (s == 5) data_in = (k == dur(5) - 1) ? d_last : d_early;
        else        data_in = 8'hE7;
        if (s == 7) begin
          chk("latency", 32'(cyc - 1), 32'(LAT));
          if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("data_out", 32'(data_out), 32'(e));
          end
          if (hold_next) begin
            start = 1'b1;
            addr  = a_next;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_ctl", 32'({AD, CS, RD, WR, ad_mux, bus_oe, read_end}), 32'(exp_ctl(0)));
    chk("idle_busy", 32'(busy), 32'd0);
    chk("held_data", 32'(data_out), 32'(d_last));
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    while (state !== s && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b1;
    addr    = 8'h00;
    data_in = 8'h00;
`ifdef READ_ABORT_EN
    abort   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctl", 32'({AD, CS, RD, WR, ad_mux, bus_oe, read_end}), 32'(exp_ctl(0)));
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bus_out", 32'(bus_out), 32'h00);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("idle_hold", 32'(state), 32'd0);

    // Nominal, capture-edge with busy-ignore and back-to-back, then the follow-on.
    run_txn(8'h21, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'h00);
    run_txn(8'h30, 8'h11, 8'hC3, 1'b1, 1'b1, 8'h23);
    run_txn(8'h23, 8'h44, 8'h66, 1'b0, 1'b0, 8'h00);

    // Reset during the read strobe.
    addr  = 8'h40;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state(3'd5, "reach_r5");
    data_in = 8'h77;
    rst     = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_rd", 32'(RD), 32'd1);
    chk("midrst_oe", 32'(bus_oe), 32'd0);
    chk("midrst_end", 32'(read_end), 32'd0);
    chk("midrst_nocap", 32'(data_out == 8'h77), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

`ifdef READ_ABORT_EN
    // Abort in the address strobe: recovery only, no completion, no capture.
    @(negedge clk);
    addr  = 8'h50;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state(3'd2, "reach_r2");
    abort   = 1'b1;
    data_in = 8'h99;
    @(negedge clk);
    abort = 1'b0;
    for (int k = 0; k < int'(T_W); k++) begin
      chk("abort_r6", 32'(state), 32'd6);
      chk("abort_noend", 32'(read_end), 32'd0);
      chk("abort_flag_lo", 32'(aborted), 32'd0);
      @(negedge clk);
    end
    chk("abort_r0", 32'(state), 32'd0);
    chk("aborted_pulse", 32'(aborted), 32'd1);
    chk("abort_noend2", 32'(read_end), 32'd0);
    chk("abort_data", 32'(data_out), 32'h00);
    @(negedge clk);
    chk("aborted_clear", 32'(aborted), 32'd0);
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
